c3lib_and_filt_sync: RTL and testbench
======================================

C3LIB_AND_FILT_SYNC -- requirements
Module: c3lib_and_filt_sync

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 2: number of AND inputs, legal range 2..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per input, legal range 0..3; 0 bypasses the synchronisers.
REQ-003 The block SHALL have parameter FILT_CYCLES, default 4: consecutive stable cycles needed to change out, legal range 1..255.
REQ-004 The block SHALL have parameter DEASSERT_FILT, default 0: 0 = out deasserts immediately, 1 = deassertion is filtered like assertion.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_async, input, NUM_IN bits: asynchronous inputs to be combined.
REQ-008 The block SHALL have port in_mask, input, NUM_IN bits: clk-synchronous; a 1 excludes that input from the AND.
REQ-009 The block SHALL have port clr, input, 1 bit: clk-synchronous filter clear.
REQ-010 The block SHALL have port out_raw, output, 1 bit: the registered, unfiltered masked AND.
REQ-011 The block SHALL have port out, output, 1 bit: the filtered AND result.

Function
REQ-012 Each in_async bit SHALL pass through SYNC_STAGES flops, reset to 0, to give in_sync.
REQ-013 raw_q SHALL register, on each edge, the AND over i of (in_sync[i] | in_mask[i]), qualified by (~&in_mask).
REQ-014 When all inputs are masked, raw_q SHALL be 0.
REQ-015 out_raw SHALL equal raw_q.
REQ-016 A saturating counter cnt, of width clog2(FILT_CYCLES+1), SHALL clear on any edge where raw_q == out.
REQ-017 On an edge where raw_q != out and cnt < FILT_CYCLES-1, cnt SHALL increment.
REQ-018 On an edge where raw_q != out and cnt == FILT_CYCLES-1, out SHALL toggle and cnt SHALL clear.
REQ-019 With DEASSERT_FILT=0, on any edge where out=1 and raw_q=0, out SHALL clear immediately and cnt SHALL clear, overriding REQ-017/018.
REQ-020 Assert latency SHALL be exactly SYNC_STAGES+1+FILT_CYCLES edges from the first edge sampling a stable-true input set.
REQ-021 A single-cycle disagreement between raw_q and out during counting SHALL restart the count from 0; no accumulation across glitches.
REQ-022 clr=1 SHALL force raw_q, cnt and out to 0 on that edge, with priority over all other updates; synchroniser flops SHALL be unaffected.
REQ-023 in_mask SHALL take effect on the edge that samples it, with no added latency.
REQ-024 All outputs SHALL be glitch-free flop outputs; no combinational path from input to output.

Reset
REQ-025 While rst_n=0, synchroniser flops, raw_q, cnt and out SHALL be 0 asynchronously, so out_raw=0 and out=0.
REQ-026 Reset deassertion SHALL be assumed synchronised externally; the first post-reset edge SHALL behave as normal operation.
REQ-027 Reset asserted mid-count SHALL discard progress; after release, the full latency of REQ-020 SHALL apply again.

Structure
REQ-028 Parameter range limits and the counter-width function SHALL reside in the shared c3lib package (c3lib_pkg); no local typedefs.
REQ-029 Per-bit synchronisation SHALL instantiate the existing c3lib_bitsync sub-module, one per input, generated when SYNC_STAGES>0.
REQ-030 The filter (cnt/out logic) SHALL be inline; the expected size is 120-250 RTL lines.

Verification
REQ-031 Scenario, with NUM_IN=4, SYNC=2, FILT=4, mask=0: hold rst_n low, drive in_async=4'hF -> out=0 and out_raw=0 throughout reset.
REQ-032 Scenario, same configuration: after reset, set in_async=4'hF at edge 0 -> out_raw=1 after edge 3 and out=1 after edge 7, not earlier.
REQ-033 Scenario: drop in_async[1] for 2 cycles starting edge 4 -> out stays 0; out rises 4 edges after raw_q returns to 1.
REQ-034 Scenario: with out=1 and DEASSERT_FILT=0, clear in_async[2] -> out=0 after edge 4 of the change; with DEASSERT_FILT=1 -> out=0 after edge 7; a 1-cycle pulse low with DEASSERT_FILT=1 -> out stays 1.
REQ-035 Scenario: in_async=4'h7 with mask=4'h8 -> out rises per REQ-032; mask=4'hF -> out_raw=0, and out falls.
REQ-036 Scenario: clr pulse at edge 5 of a count -> out=0 at edge 5 and recount; rst_n pulse mid-count -> full latency restarts.

Source files
------------

// File: rtl/c3lib_pkg.sv
// Shared c3lib parameter limits and helper functions.
// Pure declarations; no logic, no latency, no flow control.
package c3lib_pkg;

  localparam int C3_NUM_IN_MIN = 2;
  localparam int C3_NUM_IN_MAX = 32;
  localparam int C3_SYNC_MIN   = 0;
  localparam int C3_SYNC_MAX   = 3;
  localparam int C3_FILT_MIN   = 1;
  localparam int C3_FILT_MAX   = 255;

  // Width of a counter that must be able to hold 0..filt_cycles.
  function automatic int cnt_width(input int filt_cycles);
    return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/c3lib_bitsync.sv
// Single-bit synchroniser chain of STAGES flops, reset to 0.
// Latency STAGES edges; no backpressure.
module c3lib_bitsync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/c3lib_and_filt_sync.sv
// Synchronised, maskable AND of async inputs with a stability filter on the result.
// Assert latency SYNC_STAGES+1+FILT_CYCLES edges; no backpressure, clr wins over everything.
module c3lib_and_filt_sync
  import c3lib_pkg::*;
#(
  parameter int NUM_IN        = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_CYCLES   = 4,
  parameter int DEASSERT_FILT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] in_async,
  input  logic [NUM_IN-1:0] in_mask,
  input  logic              clr,
  output logic              out_raw,
  output logic              out
);

  localparam int            CW            = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST      = CW'(FILT_CYCLES - 1);
  localparam bit            FAST_DEASSERT = (DEASSERT_FILT == 0);

  generate
    if (NUM_IN < C3_NUM_IN_MIN || NUM_IN > C3_NUM_IN_MAX) begin : g_bad_num_in
      $error("c3lib_and_filt_sync: NUM_IN out of range");
    end
    if (SYNC_STAGES < C3_SYNC_MIN || SYNC_STAGES > C3_SYNC_MAX) begin : g_bad_sync
      $error("c3lib_and_filt_sync: SYNC_STAGES out of range");
    end
    if (FILT_CYCLES < C3_FILT_MIN || FILT_CYCLES > C3_FILT_MAX) begin : g_bad_filt
      $error("c3lib_and_filt_sync: FILT_CYCLES out of range");
    end
  endgenerate

  logic [NUM_IN-1:0] in_sync;
  logic              raw_d;
  logic              raw_q;
  logic [CW-1:0]     cnt;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        c3lib_bitsync #(
          .STAGES (SYNC_STAGES)
        ) u_bitsync (
          .clk   (clk),
          .rst_n (rst_n),
          .d     (in_async[i]),
          .q     (in_sync[i])
        );
      end
    end else begin : g_nosync
      assign in_sync = in_async;
    end
  endgenerate

  // A fully masked set must read as false, not as a vacuous AND.
  assign raw_d = (&(in_sync | in_mask)) & ~(&in_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      out   <= 1'b0;
    end else if (clr) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      raw_q <= raw_d;
      if (raw_q == out) begin
        cnt <= '0;
      end else if (FAST_DEASSERT && out && !raw_q) begin
        out <= 1'b0;
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out <= ~out;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out_raw = raw_q;

endmodule

// File: tb/tb_c3lib_and_filt_sync.sv
// Bench: two instances (immediate and filtered deassert) checked every cycle against a streak model.
module tb_c3lib_and_filt_sync;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int FC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_async = '0;
  logic [N-1:0] in_mask = '0;
  logic         clr = 1'b0;
  logic         out_raw0, out0, out_raw1, out1;

  always #5 clk = ~clk;

  c3lib_and_filt_sync #(
    .NUM_IN(N), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .DEASSERT_FILT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_async(in_async), .in_mask(in_mask),
    .clr(clr), .out_raw(out_raw0), .out(out0)
  );

  c3lib_and_filt_sync #(
    .NUM_IN(N), .SYNC_STAGES(SS), .FILT_CYCLES(FC), .DEASSERT_FILT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .in_async(in_async), .in_mask(in_mask),
    .clr(clr), .out_raw(out_raw1), .out(out1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] hist[$];   // in_async samples not yet visible through the synchroniser
  logic         m_raw;
  logic         m_out[2];
  int           streak[2]; // consecutive edges raw has disagreed with out

  function automatic logic spec_and(input logic [N-1:0] s, input logic [N-1:0] m);
    int   live = 0;
    logic all1 = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!m[i]) begin
        live++;
        if (!s[i]) all1 = 1'b0;
      end
    end
    return (live > 0) && all1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back('0);
    m_raw = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_out[d]  = 1'b0;
      streak[d] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] seen;
    logic         nraw;
    if (SS == 0) begin
      seen = in_async;
    end else begin
      seen = hist[0];
      hist.push_back(in_async);
      void'(hist.pop_front());
    end
    nraw = spec_and(seen, in_mask);
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        m_out[d] = 1'b0; streak[d] = 0;
      end else if (m_raw == m_out[d]) begin
        streak[d] = 0;
      end else if (d == 0 && m_out[d] && !m_raw) begin
        m_out[d] = 1'b0; streak[d] = 0;
      end else begin
        streak[d]++;
        if (streak[d] == FC) begin
          m_out[d] = ~m_out[d]; streak[d] = 0;
        end
      end
    end
    m_raw = clr ? 1'b0 : nraw;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Compare process: outputs are settled at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_raw0", out_raw0, m_raw);
      chk("model_out0", out0, m_out[0]);
      chk("model_raw1", out_raw1, m_raw);
      chk("model_out1", out1, m_out[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_edge();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_with(input logic [N-1:0] v, input logic [N-1:0] m);
    rst_n = 1'b0; clr = 1'b0; in_async = v; in_mask = m;
    for (int k = 0; k < 3; k++) begin
      wait_edge();
      chk("reset_raw", out_raw0, 1'b0);
      chk("reset_out", out0, 1'b0);
      chk("reset_out1", out1, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    // Hold in reset with all inputs true; edge 1 is the first post-release edge.
    reset_with(4'hF, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      wait_edge();
      chk("assert_raw", out_raw0, k >= 3);
      chk("assert_out", out0, k >= 7);
      chk("assert_out1", out1, k >= 7);
    end

    // Two-cycle dropout of bit 1 during the count restarts it.
    reset_with(4'hF, 4'h0);
    for (int k = 1; k <= 13; k++) begin
      wait_edge();
      if (k == 2) in_async = 4'hD;
      if (k == 4) in_async = 4'hF;
      chk("glitch_raw", out_raw0, (k >= 3) && !(k == 5 || k == 6));
      chk("glitch_out", out0, k >= 11);
    end

    // Deassertion: immediate vs filtered.
    in_async = 4'hB;
    for (int k = 1; k <= 9; k++) begin
      wait_edge();
      chk("deassert_out0", out0, k < 4);
      chk("deassert_out1", out1, k < 7);
    end
    in_async = 4'hF;
    for (int k = 0; k < 12; k++) wait_edge();
    in_async = 4'hB;
    wait_edge();
    in_async = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      wait_edge();
      chk("pulse_hold_out1", out1, 1'b1);
    end
    for (int k = 0; k < 6; k++) wait_edge();

    // Masked bit 3 is ignored; masking everything forces raw low at once.
    reset_with(4'h7, 4'h8);
    for (int k = 1; k <= 9; k++) begin
      wait_edge();
      chk("mask_raw", out_raw0, k >= 3);
      chk("mask_out", out0, k >= 7);
    end
    in_mask = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      wait_edge();
      chk("allmask_raw", out_raw0, 1'b0);
      chk("allmask_out0", out0, k < 2);
    end

    // clr at edge 5 of a count.
    reset_with(4'hF, 4'h0);
    for (int k = 1; k <= 11; k++) begin
      wait_edge();
      clr = (k == 4);
      chk("clr_raw", out_raw0, (k >= 3) && (k != 5));
      chk("clr_out", out0, k >= 10);
    end

    // Reset mid-count discards progress.
    reset_with(4'hF, 4'h0);
    for (int k = 0; k < 5; k++) wait_edge();
    rst_n = 1'b0;
    wait_edge();
    chk("midrst_out", out0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_edge();
      chk("midrst_relat_out", out0, k >= 7);
    end

    // Randomised run, biased towards long true stretches.
    for (int c = 0; c < 3000; c++) begin
      wait_edge();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 9) < 7) in_async = '1;
      else in_async = N'($urandom);
      if ($urandom_range(0, 49) == 0) in_mask = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      clr = ($urandom_range(0, 99) == 0);
    end

    wait_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
